// File: rtl/arbitro_rr_vc.sv
// Round-robin scheduler draining four first-word-fall-through VC FIFOs into one
// downstream FIFO, up to BURST words per grant, honouring almost-full back-pressure.
module arbitro_rr_vc #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned BURST  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic              almost_full_out,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic [DATA_W-1:0] data_out,
  output logic              push_out,
  output logic [1:0]        grant,
  output logic              active,
  output logic [CNT_W-1:0]  words_served
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_grant;
  logic [CNT_W-1:0]    r_ws;
  logic [DATA_W-1:0]   r_dout;
  logic                r_push;

  logic [3:0]          w_empty;
  logic [DATA_W-1:0]   w_head;
  logic                w_empty_g;
  logic [1:0]          w_winner;
  logic                w_any;
  logic                w_pop;
  logic                w_last;

  assign w_empty   = {empty3, empty2, empty1, empty0};
  assign w_empty_g = w_empty[r_grant];
  assign w_any     = ~&w_empty;

  always_comb begin
    w_head = data_in0;
    case (r_grant)
      2'd0: w_head = data_in0;
      2'd1: w_head = data_in1;
      2'd2: w_head = data_in2;
      2'd3: w_head = data_in3;
      default: w_head = data_in0;
    endcase
  end

  // Scan grant+1 .. grant+4 (mod 4); the first non-empty VC wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    w_winner = r_grant;
    found    = 1'b0;
    idx      = r_grant;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = r_grant + 2'(i);
      if (!found && !w_empty[idx]) begin
        w_winner = idx;
        found    = 1'b1;
      end
    end
  end

  assign w_pop  = (r_state == SERVE) & ~w_empty_g & ~almost_full_out & enable & reset_L;
  assign w_last = w_pop & (r_ws == CNT_W'(BURST - 1));

  always_ff @(posedge clk) begin
    if (!reset_L) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable && w_any) w_next = SERVE;
      SERVE:   if (w_last || w_empty_g || !enable) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pop0   = w_pop & (r_grant == 2'd0);
    pop1   = w_pop & (r_grant == 2'd1);
    pop2   = w_pop & (r_grant == 2'd2);
    pop3   = w_pop & (r_grant == 2'd3);
    active = (r_state == SERVE);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_grant <= 2'd3;
      r_ws    <= '0;
      r_dout  <= '0;
      r_push  <= 1'b0;
    end else begin
      r_push <= w_pop;
      if (w_pop) begin
        r_dout <= w_head;
        r_ws   <= r_ws + 1'b1;
      end
      if (r_state == IDLE && w_next == SERVE) begin
        r_grant <= w_winner;
        r_ws    <= '0;
      end
    end
  end

  assign data_out     = r_dout;
  assign push_out     = r_push;
  assign grant        = r_grant;
  assign words_served = r_ws;

endmodule

// File: tb/tb_arbitro_rr_vc.sv
// Bench for arbitro_rr_vc: queue-backed VC FIFOs, a transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_arbitro_rr_vc;
  localparam int DW    = 10;
  localparam int BURST = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset_L, enable, afull;
  logic [DW-1:0] din [4];
  logic          emp [4];
  logic          pop0, pop1, pop2, pop3, push_out, active;
  logic [DW-1:0] data_out;
  logic [1:0]    grant;
  logic [CW-1:0] words_served;

  arbitro_rr_vc #(.DATA_W(DW), .BURST(BURST), .CNT_W(CW)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .empty0(emp[0]), .empty1(emp[1]), .empty2(emp[2]), .empty3(emp[3]),
    .almost_full_out(afull),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .data_out(data_out), .push_out(push_out), .grant(grant),
    .active(active), .words_served(words_served)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q [4][$];
  logic [DW-1:0] dlog [$];
  int            glog [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, always holding the values expected after the last edge.
  bit            m_valid = 0;
  bit            m_srv   = 0;
  int            m_grant = 3;
  int            m_ws    = 0;
  logic [DW-1:0] m_dout  = '0;
  bit            m_push  = 0;
  int            m_pop_vc = -1;
  bit            prev_active = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      emp[k] = (q[k].size() == 0);
      din[k] = emp[k] ? DW'($urandom) : q[k][0];
    end
  endtask

  task automatic step();
    refresh();
    @(posedge clk);
    #1;
    if (m_pop_vc >= 0 && q[m_pop_vc].size() > 0) void'(q[m_pop_vc].pop_front());
    m_pop_vc = -1;
    refresh();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) q[k].delete();
    dlog.delete();
    glog.delete();
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    step();
    reset_L = 1'b1;
  endtask

  task automatic wait_ws(input int n);
    int c;
    c = 0;
    while (!(m_srv && m_ws == n) && c < 30) begin
      step();
      c++;
    end
    chk("wait_burst_progress", 32'(m_srv && m_ws == n), 32'd1);
  endtask

  // Compare process: outputs against model, then advance model across the coming edge.
  always @(negedge clk) begin
    int       ep;
    bit       found;
    int       v;
    logic [3:0] exp_pops;
    ep = -1;
    if (reset_L && m_valid && m_srv && enable && !afull && q[m_grant].size() > 0) ep = m_grant;
    exp_pops = '0;
    if (ep >= 0) exp_pops[ep] = 1'b1;
    if (m_valid || !reset_L) chk("pops", 32'({pop3, pop2, pop1, pop0}), 32'(exp_pops));
    if (m_valid) begin
      chk("grant", 32'(grant), 32'(m_grant));
      chk("active", 32'(active), 32'(m_srv));
      chk("words_served", 32'(words_served), 32'(m_ws));
      chk("push_out", 32'(push_out), 32'(m_push));
      chk("data_out", 32'(data_out), 32'(m_dout));
      if (push_out === 1'b1) dlog.push_back(data_out);
      if (active === 1'b1 && !prev_active) glog.push_back(int'(grant));
    end
    prev_active = (active === 1'b1);

    m_pop_vc = ep;
    if (!reset_L) begin
      m_valid = 1; m_srv = 0; m_grant = 3; m_ws = 0; m_dout = '0; m_push = 0;
    end else if (m_valid) begin
      if (!m_srv) begin
        m_push = 0;
        if (enable) begin
          found = 0;
          for (int off = 1; off <= 4; off++) begin
            v = (m_grant + off) % 4;
            if (!found && q[v].size() > 0) begin
              found = 1; m_grant = v; m_ws = 0; m_srv = 1;
            end
          end
        end
      end else begin
        if (ep >= 0) begin m_dout = q[m_grant][0]; m_push = 1; end
        else m_push = 0;
        if ((ep >= 0 && m_ws == BURST - 1) || q[m_grant].size() == 0 || !enable) m_srv = 0;
        if (ep >= 0) m_ws++;
      end
    end
  end

  initial begin
    reset_L = 1'b0; enable = 1'b1; afull = 1'b0;
    for (int k = 0; k < 4; k++) begin q[k].push_back(DW'(k)); q[k].push_back(DW'(k + 8)); end
    refresh();
    steps(2);
    chk("reset_push", 32'(push_out), 32'd0);
    chk("reset_grant", 32'(grant), 32'd3);
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_pops", 32'({pop3, pop2, pop1, pop0}), 32'd0);

    // Single VC drain
    clear_all();
    reset_L = 1'b1;
    q[2].push_back(10'h011); q[2].push_back(10'h022); q[2].push_back(10'h033);
    steps(10);
    chk("single_npush", 32'(dlog.size()), 32'd3);
    if (dlog.size() == 3) begin
      chk("single_d0", 32'(dlog[0]), 32'h011);
      chk("single_d1", 32'(dlog[1]), 32'h022);
      chk("single_d2", 32'(dlog[2]), 32'h033);
    end
    chk("single_grant", 32'(grant), 32'd2);
    chk("single_idle", 32'(active), 32'd0);

    // Fairness: 8 words in every VC
    do_reset();
    clear_all();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) q[k].push_back(DW'(k * 64 + i));
    steps(50);
    chk("fair_ngrant", 32'(glog.size()), 32'd8);
    for (int b = 0; b < 8 && b < glog.size(); b++) chk("fair_grant_seq", 32'(glog[b]), 32'(b % 4));
    chk("fair_npush", 32'(dlog.size()), 32'd32);
    for (int j = 0; j < 32 && j < dlog.size(); j++)
      chk("fair_data", 32'(dlog[j]), 32'(((j / 4) % 4) * 64 + (j / 16) * 4 + (j % 4)));

    // Back-pressure after the second pop
    do_reset();
    clear_all();
    for (int i = 0; i < 4; i++) q[0].push_back(DW'(100 + i));
    q[1].push_back(DW'(200)); q[1].push_back(DW'(201));
    wait_ws(2);
    afull = 1'b1;
    steps(3);
    chk("bp_ws_held", 32'(words_served), 32'd2);
    chk("bp_still_active", 32'(active), 32'd1);
    chk("bp_npush_stall", 32'(dlog.size()), 32'd2);
    afull = 1'b0;
    steps(15);
    chk("bp_npush", 32'(dlog.size()), 32'd6);
    chk("bp_ngrant", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("bp_grant_next", 32'(glog[1]), 32'd1);

    // Enable drop after the first pop
    do_reset();
    clear_all();
    for (int i = 0; i < 4; i++) begin q[0].push_back(DW'(300 + i)); q[1].push_back(DW'(400 + i)); end
    wait_ws(1);
    enable = 1'b0;
    step();
    chk("en_drop_idle", 32'(active), 32'd0);
    steps(3);
    chk("en_drop_ws", 32'(words_served), 32'd1);
    chk("en_drop_nopop", 32'(q[0].size()), 32'd3);
    enable = 1'b1;
    steps(20);
    chk("en_ngrant", 32'(glog.size()), 32'd3);
    if (glog.size() >= 2) chk("en_resume_next", 32'(glog[1]), 32'd1);

    // Reset mid-burst
    do_reset();
    clear_all();
    for (int i = 0; i < 5; i++) q[1].push_back(DW'(500 + i));
    wait_ws(2);
    reset_L = 1'b0;
    step();
    reset_L = 1'b1;
    chk("rst_mid_push", 32'(push_out), 32'd0);
    chk("rst_mid_grant", 32'(grant), 32'd3);
    q[0].push_back(DW'(600));
    glog.delete();
    steps(10);
    chk("rst_mid_ngrant", 32'(glog.size() > 0), 32'd1);
    if (glog.size() > 0) chk("rst_mid_vc0_first", 32'(glog[0]), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_L = ($urandom_range(99) != 0);
      enable  = ($urandom_range(9) != 0);
      afull   = ($urandom_range(3) == 0);
      for (int k = 0; k < 4; k++)
        if (q[k].size() < 12 && $urandom_range(2) == 0) q[k].push_back(DW'($urandom));
      step();
    end
    reset_L = 1'b1; enable = 1'b1; afull = 1'b0;
    steps(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
